// File: rtl/ex_muldiv_if.sv
// Handshake and HI/LO bus between the EX stage and the multiply/divide unit.
interface ex_muldiv_if #(
  parameter int NBits = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [NBits-1:0] OperandA;
  logic [NBits-1:0] OperandB;
  logic             WriteHi;
  logic             WriteLo;
  logic [NBits-1:0] HiLoWriteData;
  logic             HiLoRead;
  logic [NBits-1:0] HI;
  logic [NBits-1:0] LO;
  logic             Busy;
  logic             Stall;
  logic             Done;
  logic             DivByZero;

  modport master (
    output Start, Op, OperandA, OperandB, WriteHi, WriteLo, HiLoWriteData, HiLoRead,
    input  HI, LO, Busy, Stall, Done, DivByZero
  );

  modport slave (
    input  Start, Op, OperandA, OperandB, WriteHi, WriteLo, HiLoWriteData, HiLoRead,
    output HI, LO, Busy, Stall, Done, DivByZero
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: one bit per cycle,
// shift-add multiply and restoring divide on magnitudes, sign fix at the end.
module ex_muldiv_unit #(
  parameter int NBits = 32
) (
  input logic        clk,
  input logic        reset,
  ex_muldiv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [5:0] CNT_LOAD = 6'(NBits - 1);

  state_t state_q, state_d;

  logic [5:0]       count_q;
  logic [NBits-1:0] acc_hi;
  logic [NBits-1:0] acc_lo;
  logic [NBits-1:0] mcand;
  logic [NBits-1:0] hi_q;
  logic [NBits-1:0] lo_q;
  logic             is_div_q;
  logic             neg_main_q;
  logic             neg_rem_q;
  logic             dbz_q;

  logic             start_idle;
  logic             start_dbz;
  logic [NBits:0]   mul_sum;
  logic [NBits:0]   div_shift;
  logic             div_ge;
  logic [NBits-1:0] res_hi;
  logic [NBits-1:0] res_lo;

  // Magnitude of v when it is interpreted as signed, otherwise v unchanged.
  function automatic logic [NBits-1:0] mag(input logic [NBits-1:0] v, input logic use_sign);
    return (use_sign && v[NBits-1]) ? ({NBits{1'b0}} - v) : v;
  endfunction

  function automatic logic [NBits-1:0] neg_w(input logic [NBits-1:0] v);
    return {NBits{1'b0}} - v;
  endfunction

  function automatic logic [2*NBits-1:0] neg_p(input logic [2*NBits-1:0] v);
    return {(2*NBits){1'b0}} - v;
  endfunction

  assign start_idle = (state_q == IDLE) && bus.Start;
  assign start_dbz  = bus.Op[1] && (bus.OperandB == {NBits{1'b0}});

  // Multiply step adds the multiplicand into the upper half; divide step
  // shifts the next dividend bit into the partial remainder and trials it.
  assign mul_sum   = {1'b0, acc_hi} + {1'b0, mcand};
  assign div_shift = {acc_hi, acc_lo[NBits-1]};
  assign div_ge    = div_shift >= {1'b0, mcand};

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a divide by zero has nothing to iterate and finishes at once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.Start) state_d = start_dbz ? FINISH : RUN;
      RUN:     if (count_q == 6'd0) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and one iteration per RUN cycle on the internal accumulators.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q    <= 6'd0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      mcand      <= '0;
      is_div_q   <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      if (start_idle) begin
        count_q    <= CNT_LOAD;
        is_div_q   <= bus.Op[1];
        neg_main_q <= bus.Op[0] && (bus.OperandA[NBits-1] ^ bus.OperandB[NBits-1]);
        neg_rem_q  <= bus.Op[1] && bus.Op[0] && bus.OperandA[NBits-1];
        if (start_dbz) begin
          dbz_q  <= 1'b1;
          acc_hi <= bus.OperandA;
          acc_lo <= '1;
          mcand  <= '0;
        end else begin
          dbz_q  <= 1'b0;
          acc_hi <= '0;
          // Divide keeps the divisor in mcand and the dividend in acc_lo;
          // multiply keeps the multiplicand in mcand and the multiplier in acc_lo.
          mcand  <= bus.Op[1] ? mag(bus.OperandB, bus.Op[0]) : mag(bus.OperandA, bus.Op[0]);
          acc_lo <= bus.Op[1] ? mag(bus.OperandA, bus.Op[0]) : mag(bus.OperandB, bus.Op[0]);
        end
      end else if (state_q == RUN) begin
        if (count_q != 6'd0) count_q <= count_q - 6'd1;
        if (is_div_q) begin
          acc_hi <= div_ge ? NBits'(div_shift - {1'b0, mcand}) : div_shift[NBits-1:0];
          acc_lo <= {acc_lo[NBits-2:0], div_ge};
        end else if (acc_lo[0]) begin
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[NBits-1:1]};
        end else begin
          {acc_hi, acc_lo} <= {1'b0, acc_hi, acc_lo[NBits-1:1]};
        end
      end
    end
  end

  // Sign correction of the magnitude result, applied while in FINISH.
  always_comb begin
    res_hi = acc_hi;
    res_lo = acc_lo;
    if (!dbz_q) begin
      if (!is_div_q) begin
        if (neg_main_q) {res_hi, res_lo} = neg_p({acc_hi, acc_lo});
      end else begin
        if (neg_main_q) res_lo = neg_w(acc_lo);
        if (neg_rem_q)  res_hi = neg_w(acc_hi);
      end
    end
  end

  // Architectural HI/LO: result capture at the end of FINISH, MT writes only in IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == FINISH) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if (state_q == IDLE) begin
      if (bus.WriteHi) hi_q <= bus.HiLoWriteData;
      if (bus.WriteLo) lo_q <= bus.HiLoWriteData;
    end
  end

  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;
  assign bus.Busy      = (state_q != IDLE);
  assign bus.Stall     = bus.Busy && (bus.Start || bus.HiLoRead || bus.WriteHi || bus.WriteLo);
  // Gated by reset so an operation aborted in its FINISH cycle shows no Done.
  assign bus.Done      = (state_q == FINISH) && reset;
  assign bus.DivByZero = bus.Done && dbz_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed plus light random bench for ex_muldiv_unit with a result scoreboard.
module tb_ex_muldiv_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          busy;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  exp_t sb[$];

  ex_muldiv_if #(.NBits(32)) bus();

  ex_muldiv_unit #(.NBits(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour computed with native wide arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    e.dbz  = 1'b0;
    e.busy = 33;
    e.hi   = '0;
    e.lo   = '0;
    case (op)
      2'b00: begin
        p = {32'b0, a} * {32'b0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      2'b01: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1; e.busy = 1;
        end else if (op == 2'b10) begin
          e.lo = a / b; e.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = 32'h0;
        end else begin
          e.lo = $signed(a) / $signed(b);
          e.hi = $signed(a) % $signed(b);
        end
      end
    endcase
    return e;
  endfunction

  task automatic clear_side();
    bus.WriteHi = 1'b0; bus.WriteLo = 1'b0; bus.HiLoRead = 1'b0; bus.HiLoWriteData = '0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input bit mt_lo);
    exp_t        e;
    exp_t        got;
    int          n;
    int          guard;
    bit          seen;
    logic        dz;
    logic [31:0] hs;
    logic [31:0] ls;
    e = model(op, a, b);
    sb.push_back(e);
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = op; bus.OperandA = a; bus.OperandB = b;
    if (mt_lo) begin bus.WriteLo = 1'b1; bus.HiLoWriteData = 32'h5555_AAAA; end
    @(posedge clk); #1;
    bus.Start = 1'b0; bus.OperandA = ~a; bus.OperandB = ~b;
    clear_side();
    if (mt_lo) chk("mt_with_start_lo", bus.LO, 32'h5555_AAAA);
    hs = bus.HI; ls = bus.LO;
    n = 0; guard = 0; seen = 0; dz = 1'b0;
    while (!seen && guard < 100) begin
      @(negedge clk);
      guard++;
      if (bus.Busy) n++;
      if (bus.Done) begin
        seen = 1;
        dz = bus.DivByZero;
      end else begin
        chk("dbz_low_outside_finish", bus.DivByZero, 1'b0);
      end
      if (disturb && guard >= 3 && guard <= 5) begin
        bus.Start = 1'b1; bus.Op = 2'b11; bus.OperandB = '0;
        bus.WriteHi = 1'b1; bus.WriteLo = 1'b1; bus.HiLoWriteData = 32'hDEAD_BEEF;
        bus.HiLoRead = 1'b1;
        #1;
        chk("stall_while_busy", bus.Stall, 1'b1);
        chk("hi_held_in_run", bus.HI, hs);
        chk("lo_held_in_run", bus.LO, ls);
      end else begin
        bus.Start = 1'b0;
        clear_side();
      end
    end
    chk("done_seen", seen, 1'b1);
    @(posedge clk); #1;
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk("result_hi", bus.HI, got.hi);
      chk("result_lo", bus.LO, got.lo);
      chk("div_by_zero_flag", dz, got.dbz);
      chk("busy_cycles", n, got.busy);
    end
    chk("idle_after_done", bus.Busy, 1'b0);
    chk("done_one_cycle", bus.Done, 1'b0);
  endtask

  task automatic mt_write(input bit to_hi, input logic [31:0] d);
    logic [31:0] other;
    @(negedge clk);
    other = to_hi ? bus.LO : bus.HI;
    if (to_hi) bus.WriteHi = 1'b1; else bus.WriteLo = 1'b1;
    bus.HiLoWriteData = d;
    @(posedge clk); #1;
    clear_side();
    chk(to_hi ? "mthi_value" : "mtlo_value", to_hi ? bus.HI : bus.LO, d);
    chk("mt_other_unchanged", to_hi ? bus.LO : bus.HI, other);
  endtask

  initial begin
    int   done_cnt;
    int   busy_cnt;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    checks = 0; failures = 0;
    reset = 1'b0;
    bus.Start = 1'b0; bus.Op = 2'b00; bus.OperandA = '0; bus.OperandB = '0;
    clear_side();

    // Reset has priority over requests and MT writes.
    @(negedge clk);
    bus.Start = 1'b1; bus.HiLoRead = 1'b1; bus.WriteHi = 1'b1; bus.HiLoWriteData = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_busy", bus.Busy, 1'b0);
    chk("reset_stall", bus.Stall, 1'b0);
    chk("reset_done", bus.Done, 1'b0);
    chk("reset_hi", bus.HI, 32'h0);
    chk("reset_lo", bus.LO, 32'h0);
    @(negedge clk);
    bus.Start = 1'b0; clear_side();
    reset = 1'b1;

    mt_write(1'b1, 32'h0000_1234);
    mt_write(1'b0, 32'hCAFE_0001);

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 0, 0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
    run_op(2'b10, 32'd100,       32'd7,         0, 0);
    run_op(2'b10, 32'd10,        32'd0,         0, 0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(2'b11, 32'hFFFF_FFFB, 32'd0,         0, 0);
    run_op(2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0);
    run_op(2'b11, 32'd7,         32'hFFFF_FFFE, 0, 0);
    run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 1, 0);
    run_op(2'b00, 32'd2,         32'd3,         0, 1);

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 2) ? 32'd0 : ((i == 4) ? 32'($urandom_range(1, 15)) : $urandom);
      run_op(rop, ra, rb, 0, 0);
    end

    // Abort an operation on RUN cycle 10; HI/LO hold a nonzero value beforehand.
    run_op(2'b10, 32'h0000_ABCD, 32'd0, 0, 0);
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = 2'b00; bus.OperandA = 32'hFFFF_FFFF; bus.OperandB = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", bus.Busy, 1'b0);
    chk("abort_hi", bus.HI, 32'h0);
    chk("abort_lo", bus.LO, 32'h0);
    chk("abort_stall", bus.Stall, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    done_cnt = 0; busy_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.Done) done_cnt++;
      if (bus.Busy) busy_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_resume", busy_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 Parameter NBits, default 32, operand and HI/LO width; the block SHALL be verified only at 32.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 Start  input  1  request sampled high when state=IDLE starts an operation.
REQ-005 Op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with Start.
REQ-006 OperandA  input  NBits  rs value after forwarding: multiplicand or dividend.
REQ-007 OperandB  input  NBits  rt value after forwarding: multiplier or divisor.
REQ-008 WriteHi, WriteLo  input  1 each  MTHI/MTLO write enables.
REQ-009 HiLoWriteData  input  NBits  data for MTHI/MTLO.
REQ-010 HiLoRead  input  1  MFHI/MFLO present in EX.
REQ-011 HI, LO  output  NBits  architectural registers, driven directly from flops.
REQ-012 Busy  output  1  high whenever state≠IDLE.
REQ-013 Stall  output  1  combinational: Busy AND (Start OR HiLoRead OR WriteHi OR WriteLo).
REQ-014 Done  output  1  one-cycle pulse on the cycle HI/LO capture a result.
REQ-015 DivByZero  output  1  one-cycle pulse, coincident with Done, for a divide with OperandB=0.

Function
REQ-016 FSM states SHALL be IDLE, RUN, FINISH.
REQ-017 IDLE→RUN on Start; Op and operands latched; the 6-bit counter is loaded with 31.
REQ-018 A divide with OperandB=0 SHALL go IDLE→FINISH directly, skipping RUN.
REQ-019 RUN iterates one bit per cycle; counter decrements; RUN→FINISH when counter=0 after exactly 32 RUN cycles.
REQ-020 FINISH lasts one cycle: sign fix applied, HI/LO written at its closing edge, Done=1, then →IDLE.
REQ-021 Latency: Busy high for 33 cycles (32 RUN + 1 FINISH); div-by-zero Busy high for 1 cycle.
REQ-022 Multiply: shift-add on magnitudes; 64-bit product {HI,LO}.
REQ-023 MULT: the product SHALL be two's-complement negated (64-bit) when the operand signs differ.
REQ-024 Divide: restoring algorithm on magnitudes; LO=quotient, HI=remainder.
REQ-025 DIV: the quotient SHALL be negated when the signs differ; the remainder SHALL take the dividend's sign.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000; no flag.
REQ-027 Divide by zero SHALL give HI=OperandA, LO=0xFFFFFFFF, DivByZero=1.
REQ-028 Start while Busy SHALL be ignored; Stall holds the pipeline so the request is re-presented in IDLE.
REQ-029 WriteHi/WriteLo in IDLE SHALL update the register at the next edge.
REQ-030 WriteHi/WriteLo while Busy SHALL be ignored; Stall is asserted.
REQ-031 Start and WriteHi/WriteLo together in IDLE: the MT write takes effect; the later result overwrites it.
REQ-032 HI/LO SHALL hold their value during RUN; partial results are kept in internal registers only.
REQ-033 Done and DivByZero SHALL be low at all times other than FINISH.

Reset
REQ-034 reset=0 at an edge SHALL force state=IDLE, counter=0, HI=LO=0, Busy=0, Done=0, DivByZero=0, internal accumulators=0.
REQ-035 Reset SHALL take priority over Start, MT writes and any in-flight operation; an aborted operation SHALL produce no Done.
REQ-036 Stall SHALL be 0 during reset because Busy=0.

Verification
REQ-037 MULTU 0xFFFFFFFF×0xFFFFFFFF → Busy for 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001, Done pulse.
REQ-038 MULT 0xFFFFFFFD(-3)×5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-039 DIV 0xFFFFFFF9(-7)/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 → LO=14, HI=2.
REQ-040 DIVU 10/0 → Busy 1 cycle, Done=DivByZero=1, HI=0x0000000A, LO=0xFFFFFFFF.
REQ-041 Reset pulled low on RUN cycle 10 → next edge IDLE, HI=LO=0, Busy=0, no Done.
REQ-042 Start and HiLoRead while Busy → Stall=1, no restart, HI/LO unchanged until FINISH; MTHI 0x1234 in IDLE → HI=0x1234 next cycle.
